de_ex_pipe: RTL

DE_EX_PIPE -- requirements
Module: de_ex_pipe

---
 rtl/riscv_pipe_pkg.sv | 35 +++
 rtl/de_ex_skid.sv | 39 +++
 rtl/de_ex_pipe.sv | 123 ++++++++++++
 3 files changed

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg -- shared types for the decode->execute pipeline register.
//   de_ex_payload_t : packed decode bundle handed to the execute stage.
//   DE_EX_NOP       : all-zero payload (reset value, harmless bubble).
// Data fields are sized to XLEN_MAX. A de_ex_pipe instance with a smaller
// XLEN keeps only the low XLEN bits and reads zero above them.
package riscv_pipe_pkg;

  localparam int XLEN_MAX    = 64;
  localparam int RD_W        = 5;
  localparam int ALU_OP_W    = 4;
  localparam int ALU_A_SRC_W = 2;
  localparam int DM_CTRL_W   = 3;
  localparam int BR_OP_W     = 5;
  localparam int RU_SRC_W    = 2;

  typedef struct packed {
    logic [XLEN_MAX-1:0]    pc;
    logic [XLEN_MAX-1:0]    pc_inc;
    logic [XLEN_MAX-1:0]    rs1;
    logic [XLEN_MAX-1:0]    rs2;
    logic [XLEN_MAX-1:0]    imm;
    logic [RD_W-1:0]        rd;
    logic [ALU_OP_W-1:0]    alu_op;
    logic [ALU_A_SRC_W-1:0] alu_a_src;
    logic                   alu_b_src;
    logic                   dm_write;
    logic [DM_CTRL_W-1:0]   dm_ctrl;
    logic [BR_OP_W-1:0]     br_op;
    logic [RU_SRC_W-1:0]    ru_data_src;
    logic                   ru_write;
  } de_ex_payload_t;

  localparam de_ex_payload_t DE_EX_NOP = '0;

endpackage

// File: rtl/de_ex_skid.sv
// de_ex_skid -- one-entry holding slot used when the pipe register is
// stalled and a new instruction has already been accepted.
//   clk, rst_n : clock, async active-low reset (slot empties)
//   i_load     : capture i_payload, slot becomes full
//   i_clear    : empty the slot (drained into the main register, or flush);
//                wins over i_load
//   o_payload  : held instruction
//   o_full     : slot occupied (registered)
module de_ex_skid
  import riscv_pipe_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_load,
  input  logic           i_clear,
  input  de_ex_payload_t i_payload,
  output de_ex_payload_t o_payload,
  output logic           o_full
);

  logic           r_full;
  de_ex_payload_t r_payload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full    <= 1'b0;
      r_payload <= DE_EX_NOP;
    end else if (i_clear) begin
      r_full    <= 1'b0;
    end else if (i_load) begin
      r_full    <= 1'b1;
      r_payload <= i_payload;
    end
  end

  assign o_payload = r_payload;
  assign o_full    = r_full;

endmodule

// File: rtl/de_ex_pipe.sv
// de_ex_pipe -- valid/ready pipeline register between decode and execute.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : decode-side handshake, in_payload captured on transfer
//   flush                 : kill held and incoming instruction (taken branch)
//   out_valid/out_ready   : execute-side handshake, out_payload held while stalled
//   bubble_cnt            : saturating count of cycles with out_valid=0
// Build option: define DE_EX_SKID_EN to add a one-entry skid slot; in_ready
// then comes straight from a flop (skid empty) and has no path from out_ready.
// Without it, in_ready = !out_valid || out_ready.
module de_ex_pipe
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  de_ex_payload_t   in_payload,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output de_ex_payload_t   out_payload,
  output logic [CNT_W-1:0] bubble_cnt
);

  // Bits above XLEN / RADDR_W are not part of this configuration; they are
  // zeroed on capture so those flops become constants.
  localparam logic [XLEN_MAX-1:0] XMASK = {XLEN_MAX{1'b1}} >> (XLEN_MAX - XLEN);
  localparam logic [RD_W-1:0]     RMASK = {RD_W{1'b1}} >> (RD_W - RADDR_W);

  logic             r_valid;
  de_ex_payload_t   r_payload;
  logic [CNT_W-1:0] r_bubble;
  de_ex_payload_t   w_in_trim;

  always_comb begin
    w_in_trim        = in_payload;
    w_in_trim.pc     = in_payload.pc     & XMASK;
    w_in_trim.pc_inc = in_payload.pc_inc & XMASK;
    w_in_trim.rs1    = in_payload.rs1    & XMASK;
    w_in_trim.rs2    = in_payload.rs2    & XMASK;
    w_in_trim.imm    = in_payload.imm    & XMASK;
    w_in_trim.rd     = in_payload.rd     & RMASK;
  end

`ifdef DE_EX_SKID_EN
  logic           w_skid_full;
  logic           w_main_free;
  logic           w_accept;
  de_ex_payload_t w_skid_payload;

  // Main register can take a new entry when empty or draining this cycle.
  assign w_main_free = !r_valid || out_ready;
  assign w_accept    = in_valid && !w_skid_full && !flush;
  assign in_ready    = !w_skid_full;

  de_ex_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_accept && !w_main_free),
    .i_clear   (flush || (w_skid_full && w_main_free)),
    .i_payload (w_in_trim),
    .o_payload (w_skid_payload),
    .o_full    (w_skid_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_payload <= DE_EX_NOP;
    end else if (flush) begin
      r_valid   <= 1'b0;
    end else if (w_skid_full) begin
      // Skid only fills behind a stalled main entry; it moves up in order.
      if (w_main_free) begin
        r_valid   <= 1'b1;
        r_payload <= w_skid_payload;
      end
    end else if (w_main_free) begin
      r_valid <= w_accept;
      if (w_accept) r_payload <= w_in_trim;
    end
  end
`else
  assign in_ready = !r_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_payload <= DE_EX_NOP;
    end else if (flush) begin
      r_valid   <= 1'b0;
    end else if (in_ready) begin
      r_valid <= in_valid;
      if (in_valid) r_payload <= w_in_trim;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_bubble <= '0;
    else if (!r_valid && (r_bubble != '1))
      r_bubble <= r_bubble + 1'b1;
  end

  // A stale payload stays in the register after a drain or flush; mask its
  // architectural side effects so execute never writes from a bubble.
  always_comb begin
    out_payload = r_payload;
    if (!r_valid) begin
      out_payload.ru_write = 1'b0;
      out_payload.dm_write = 1'b0;
    end
  end

  assign out_valid  = r_valid;
  assign bubble_cnt = r_bubble;

endmodule
